// File: rtl/cmp_pkg.sv
// Shared types and result encodings for the serial magnitude comparator.
package cmp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [2:0] cmp_res_t;
  localparam cmp_res_t RES_GT = 3'b100;
  localparam cmp_res_t RES_EQ = 3'b010;
  localparam cmp_res_t RES_LT = 3'b001;
endpackage

// File: rtl/cmp_slice.sv
// Cascadable W-bit magnitude compare; the local slice dominates, a local tie passes the cascade through.
module cmp_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_lt,
  input  logic         i_eq,
  input  logic         i_gt,
  output logic         o_lt,
  output logic         o_eq,
  output logic         o_gt
);
  always_comb begin
    o_lt = i_lt;
    o_eq = i_eq;
    o_gt = i_gt;
    if (i_a > i_b) begin
      o_lt = 1'b0; o_eq = 1'b0; o_gt = 1'b1;
    end else if (i_a < i_b) begin
      o_lt = 1'b1; o_eq = 1'b0; o_gt = 1'b0;
    end
  end
endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// Compares two DATA_W operands MSB-slice first through a single cmp_slice,
// exiting on the first unequal slice.
module serial_mag_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int SLICE_W = 4,
  localparam int NSLICE = DATA_W / SLICE_W,
  localparam int CW = $clog2(NSLICE + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_signed,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_res,
  output logic [CW-1:0]     out_cycles,
  output logic              busy
);
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((DATA_W % SLICE_W) != 0 || NSLICE < 2) begin : g_bad_param
    $error("serial_mag_cmp_ctrl: DATA_W must be a multiple of SLICE_W with at least 2 slices");
  end

  state_t            r_state;
  logic [DATA_W-1:0] r_a, r_b;
  logic              r_signed;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cyc;
  cmp_res_t          r_res;
  logic [CW-1:0]     r_cycles;

  logic [SLICE_W-1:0] w_sa, w_sb, w_msk;
  logic               w_lt, w_eq, w_gt, w_last;

  assign w_sa = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_sb = r_b[r_idx*SLICE_W +: SLICE_W];
  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign w_msk = SLICE_W'(r_signed && (r_idx == IW'(NSLICE - 1))) << (SLICE_W - 1);
  assign w_last = (r_idx == '0);

  cmp_slice #(.W(SLICE_W)) u_slice (
    .i_a  (w_sa ^ w_msk),
    .i_b  (w_sb ^ w_msk),
    .i_lt (1'b0),
    .i_eq (1'b1),
    .i_gt (1'b0),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_cyc    <= '0;
      r_res    <= '0;
      r_cycles <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid && !abort) begin
          r_a      <= in_a;
          r_b      <= in_b;
          r_signed <= in_signed;
          r_idx    <= IW'(NSLICE - 1);
          r_cyc    <= '0;
          r_state  <= RUN;
        end
        RUN: if (abort) begin
          r_state <= IDLE;
        end else begin
          r_cyc <= r_cyc + 1'b1;
          if (w_gt || w_lt || w_last) begin
            r_res    <= {w_gt, w_eq, w_lt};
            r_cycles <= r_cyc + 1'b1;
            r_state  <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: if (abort || out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign out_res    = r_res;
  assign out_cycles = r_cycles;
endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Randomized and directed checks of serial_mag_cmp_ctrl against an arithmetic reference model.
module tb_serial_mag_cmp_ctrl;
  localparam int DW = 16;
  localparam int SW = 4;
  localparam int NS = DW / SW;
  localparam int CW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_signed, abort;
  logic [DW-1:0] in_a, in_b;
  logic          out_valid, out_ready, busy;
  logic [2:0]    out_res;
  logic [CW-1:0] out_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  serial_mag_cmp_ctrl #(.DATA_W(DW), .SLICE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_cycles(out_cycles), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_res(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
    logic signed [DW-1:0] sa, sb;
    sa = a;
    sb = b;
    if (s) return (sa > sb) ? 3'b100 : (sa < sb) ? 3'b001 : 3'b010;
    return (a > b) ? 3'b100 : (a < b) ? 3'b001 : 3'b010;
  endfunction

  // 1-based position from the top of the first differing slice, NS when equal.
  function automatic int ref_k(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int k = 1; k <= NS; k++)
      if (a[(NS-k)*SW +: SW] != b[(NS-k)*SW +: SW]) return k;
    return NS;
  endfunction

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s, input int hold);
    int w, lat, k;
    logic [2:0] er;
    er = ref_res(a, b, s);
    k  = ref_k(a, b);
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("acc_rdy", in_ready, 1);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_rdy", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("latency", lat, k + 1);
    chk("res", out_res, er);
    chk("cycles", out_cycles, k);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_vld", out_valid, 1);
      chk("hold_res", out_res, er);
      chk("hold_cyc", out_cycles, k);
      chk("hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_vld", out_valid, 0);
    chk("rel_rdy", in_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] a, b;
    int mode;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_res", out_res, 0);
    chk("rst_cyc", out_cycles, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'hA000, 16'h1000, 1'b0, 0);
    do_op(16'hA000, 16'h1000, 1'b1, 0);
    do_op(16'h1234, 16'h1235, 1'b0, 0);
    do_op(16'h1235, 16'h1234, 1'b0, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
    do_op(16'h8000, 16'h7FFF, 1'b1, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 0);
    do_op(16'hFFFF, 16'h0000, 1'b0, 5);
    do_op(16'h0042, 16'h0041, 1'b1, 0);

    // abort during the second RUN cycle
    in_a = 16'h1234; in_b = 16'h1235; in_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt_busy", busy, 0);
    chk("abt_vld", out_valid, 0);
    repeat (4) begin
      @(negedge clk);
      chk("abt_novld", out_valid, 0);
    end
    do_op(16'h0001, 16'h0002, 1'b0, 0);

    // abort coincident with an accept in IDLE drops the accept
    in_a = 16'h5555; in_b = 16'h1111; in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("idle_abt_busy", busy, 0);
    chk("idle_abt_rdy", in_ready, 1);

    // async reset between clock edges in RUN
    in_a = 16'h1234; in_b = 16'h1235; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rdy", in_ready, 1);
    chk("arst_vld", out_valid, 0);
    chk("arst_res", out_res, 0);
    chk("arst_cyc", out_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h7000, 16'h7001, 1'b1, 1);

    for (int n = 0; n < 60; n++) begin
      a = DW'($urandom);
      mode = int'($urandom_range(0, 3));
      if (mode == 0) b = a;
      else if (mode == 1) b = DW'($urandom);
      else b = a ^ (DW'(1) << $urandom_range(0, DW - 1));
      do_op(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_mag_cmp_ctrl.md
Name: serial_mag_cmp_ctrl

Overview:
- Sequencer that compares two wide operands by driving one narrow cascadable magnitude-compare slice over several cycles.
- Slices are processed MSB-first, one slice per cycle, with early exit on the first unequal slice.
- Sits between an operand-producing unit and a result consumer, with valid/ready handshakes on both sides.
- Lets the team reuse a small comparator slice in place of a full-width comparator tree.

Parameters:
- DATA_W, 32: operand width. Must be an integer multiple of SLICE_W; elaboration error otherwise.
- SLICE_W, 4: width of one compare slice.
- NSLICE, DATA_W/SLICE_W: derived, not overridable. Must be ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- abort  in  1  drop the operation in flight.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  3  one-hot result {gt,eq,lt}.
- out_cycles  out  $clog2(NSLICE+1)  number of RUN cycles used.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE; in_ready=1; out_valid=0; out_res=3'b000; out_cycles=0; busy=0.
  - Internal operand registers and slice index are cleared to 0.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_a, in_b, in_signed; idx=NSLICE-1; cyc=0; next state RUN.
- State RUN:
  - in_ready=0. Slice idx bits [idx*SLICE_W +: SLICE_W] of A and B feed the cmp_slice, with cascade input eq=1.
  - Signed mode, top slice only: the MSB of both slice operands is inverted before comparing. This gives the two's-complement ordering.
  - Each RUN cycle cyc increments.
  - If the slice result is gt or lt, or idx==0: register out_res and out_cycles=cyc+1; next state DONE.
  - Otherwise idx decrements and the state stays RUN.
- State DONE:
  - out_valid=1. out_res and out_cycles are held stable while out_valid&&!out_ready.
  - On out_ready: next state IDLE, out_valid deasserts on the next cycle.
  - in_ready stays 0 in DONE; there is no overlap or bypass.
- Latency:
  - Accept to out_valid = k+1 edges, where k is the 1-based position from the top of the first differing slice, or k=NSLICE if the operands are equal.
  - Minimum latency is 2 (top slice differs). Maximum is NSLICE+1.
- abort:
  - In RUN or DONE: next state IDLE. out_valid drops next cycle. No result is delivered, and out_res is not updated in RUN.
  - In IDLE: ignored. abort in the same cycle as an in_valid accept also ignores that accept.
  - abort takes priority over out_ready in DONE.
- out_res encodings: gt=3'b100, eq=3'b010, lt=3'b001. Any other value is illegal once out_valid=1.
- All outputs are registered or decoded directly from state. No combinational path from in_* to out_*.

Decomposition:
- Package cmp_pkg holds:
  - typedef enum state_t {IDLE, RUN, DONE};
  - localparams RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001;
  - typedef cmp_res_t as logic [2:0].
- One sub-module, cmp_slice: purely combinational SLICE_W-bit magnitude compare.
  - Inputs: cascade lt/eq/gt in.
  - Outputs: one-hot lt/eq/gt. The local slice dominates; on a local equal the cascade input passes through.
- The controller instantiates exactly one cmp_slice.

Test Plan (DATA_W=16, SLICE_W=4 unless stated):
- Top-slice difference: A=0xA000, B=0x1000, unsigned -> out_res=100, out_cycles=1, out_valid 2 edges after accept. Same operands with in_signed=1 -> out_res=001, out_cycles=1.
- Bottom-slice difference: A=0x1234, B=0x1235 -> out_res=001, out_cycles=4, out_valid 5 edges after accept. Swapped operands -> 100.
- Equal and signed extremes:
  - A=B=0xFFFF -> 010, out_cycles=4.
  - Signed A=0x8000, B=0x7FFF -> 001.
  - Signed A=0xFFFF, B=0x0000 -> 001.
  - Unsigned A=0xFFFF, B=0x0000 -> 100.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_res, out_cycles stable and in_ready=0 throughout. The release cycle returns to IDLE. A back-to-back second op is accepted on the next cycle.
- Abort: assert abort during the 2nd RUN cycle of A=0x1234, B=0x1235 -> no out_valid pulse, busy=0 the next cycle. A following op A=0x0001, B=0x0002 returns 001.
- Async reset mid-RUN: drop rst_n between edges -> outputs go to reset values immediately, without waiting for a clock edge. After release the block accepts a new op normally.
